// File: rtl/muldiv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_seq_ctrl
//
// Iterative multiply/divide sequencer that sits beside the EX-stage ALU.
// It accepts MULT/MULTU/DIV/DIVU and performs one shift-add (multiply) or one
// restoring-subtract (divide) step per cycle. A final FIX cycle applies the
// result signs and commits HI/LO. It also serves MFHI/MFLO reads and raises
// stall to the hazard logic while an operation is in flight.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      EX holds an R-type muldiv/mf instruction
//   funct    in   6      MULT/MULTU/DIV/DIVU/MFHI/MFLO function code
//   op_a     in   WIDTH  rs value (multiplicand / dividend)
//   op_b     in   WIDTH  rt value (multiplier / divisor)
//   flush    in   1      pipeline flush; aborts the current operation
//   busy     out  1      operation in flight
//   stall    out  1      busy & start
//   done     out  1      one-cycle pulse: HI/LO just updated
//   hi       out  WIDTH  HI register
//   lo       out  WIDTH  LO register
//   div_zero out  1      (MULDIV_DIVZ_EN only) last divide had a zero divisor
//   mf_data  out  WIDTH  HI for MFHI, otherwise LO
//
// Optional feature: define MULDIV_DIVZ_EN to add the registered div_zero
// flag. Without it the port and its logic are absent.
// ---------------------------------------------------------------------------
module muldiv_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
`ifdef MULDIV_DIVZ_EN
    output logic             div_zero,
`endif
    output logic [WIDTH-1:0] mf_data
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Shared 2*WIDTH working register.
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d; // negate product / quotient
    logic               neg_rem_q, neg_rem_d; // dividend was negative
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // ---------------------------------------------------------------- decode
    logic             is_mul_f, is_div_f, signed_f, accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_mul_f = (funct == F_MULT) || (funct == F_MULTU);
    assign is_div_f = (funct == F_DIV)  || (funct == F_DIVU);
    assign signed_f = (funct == F_MULT) || (funct == F_DIV);
    // Flush wins over a simultaneous start; MF and unknown functs never start.
    assign accept   = (state_q == S_IDLE) && start && !flush && (is_mul_f || is_div_f);

    assign a_neg = signed_f & op_a[WIDTH-1];
    assign b_neg = signed_f & op_b[WIDTH-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    // ------------------------------------------------------- multiply step
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // The carry out of the add becomes the new top bit after the right shift.
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // --------------------------------------------------------- divide step
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_borrow;
    logic [2*WIDTH-1:0] div_next;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign div_shift  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff   = div_shift - {1'b0, opnd_q};
    // The remainder is always below the divisor, so bit WIDTH of the
    // difference is set exactly when the trial subtraction underflows.
    assign div_borrow = div_diff[WIDTH];
    assign div_next   = {(div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], ~div_borrow};

    // ------------------------------------------------------ sign correction
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   rem_mag, quo_mag, rem_fix, quo_fix;
    logic               div_by_zero;

    assign div_by_zero = (opnd_q == '0);
    assign prod_fix    = neg_res_q ? -acc_q : acc_q;
    assign rem_mag     = acc_q[2*WIDTH-1:WIDTH];
    assign quo_mag     = acc_q[WIDTH-1:0];
    // With a zero divisor every trial subtraction succeeds, so the remainder
    // ends up holding the dividend magnitude; restoring the dividend sign
    // gives back op_a exactly. Only the quotient needs overriding.
    assign rem_fix     = neg_rem_q ? -rem_mag : rem_mag;
    assign quo_fix     = div_by_zero ? '1 : (neg_res_q ? -quo_mag : quo_mag);

    // ------------------------------------------------------ next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = is_div_f ? S_DIV : S_MUL;
                    cnt_d     = '0;
                    opnd_d    = is_div_f ? b_mag : a_mag;
                    acc_d     = {{WIDTH{1'b0}}, (is_div_f ? a_mag : b_mag)};
                    is_div_d  = is_div_f;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = (state_q == S_MUL) ? mul_next : div_next;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

`ifdef MULDIV_DIVZ_EN
    logic divz_q;

    // Cleared on acceptance so it always describes the latest operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divz_q <= 1'b0;
        end else if (accept) begin
            divz_q <= 1'b0;
        end else if ((state_q == S_FIX) && !flush && is_div_q) begin
            divz_q <= div_by_zero;
        end
    end

    assign div_zero = divz_q;
`endif

    // --------------------------------------------------------------- outputs
    assign busy    = (state_q != S_IDLE);
    assign stall   = busy & start;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign mf_data = (funct == F_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for muldiv_seq_ctrl (WIDTH=32). Table of directed vectors,
// hand-written sequences for the multi-cycle corner cases, and randomized
// operations checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_muldiv_seq_ctrl;

    localparam int W       = 32;
    localparam int LAT     = W + 1;
    localparam int LAT_MAX = 100;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [5:0]   funct;
    logic [W-1:0] op_a, op_b;
    logic         flush;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo, mf_data;
`ifdef MULDIV_DIVZ_EN
    logic         div_zero;
`endif

    muldiv_seq_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .funct   (funct),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
`ifdef MULDIV_DIVZ_EN
        .div_zero(div_zero),
`endif
        .mf_data (mf_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic plus the architectural special cases.
    function automatic void ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] eh, output logic [31:0] el);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        sa = a;
        sb = b;
        eh = '0;
        el = '0;
        case (f)
            F_MULT: begin
                sp = longint'(sa) * longint'(sb);
                eh = sp[63:32];
                el = sp[31:0];
            end
            F_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            F_DIV: begin
                if (b == 32'd0) begin
                    eh = a;
                    el = '1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    eh = 32'd0;
                    el = 32'h8000_0000;
                end else begin
                    el = sa / sb;
                    eh = sa % sb;
                end
            end
            F_DIVU: begin
                if (b == 32'd0) begin
                    eh = a;
                    el = '1;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one op (called away from a clock edge); returns at the done
    // cycle (or after LAT_MAX cycles) with the latency and busy-cycle count.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcyc);
        funct = f;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef MULDIV_DIVZ_EN
        check("div_zero_cleared_on_accept", div_zero, 0);
`endif
        lat  = 0;
        bcyc = 0;
        while (done !== 1'b1 && lat < LAT_MAX) begin
            if (busy) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
        $display("op funct=%b a=%h b=%h -> hi=%h lo=%h latency=%0d busy=%0d", f, a, b, hi, lo, lat, bcyc);
    endtask

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic        dz;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int          lat, bcyc, n, bad, bad_hold, ndone;
        logic [31:0] eh, el, old_hi, old_lo;

        vecs[0]  = '{F_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[1]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{F_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[4]  = '{F_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[5]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[6]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[9]  = '{F_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
        vecs[10] = '{F_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        vecs[11] = '{F_MULTU, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 1'b0};

        // ------------------------------------------------------------ reset
        rst_n = 1'b0;
        start = 1'b1;
        funct = F_MFHI;
        op_a  = '0;
        op_b  = '0;
        flush = 1'b0;
        #12;
        check("reset_busy",    busy,    0);
        check("reset_done",    done,    0);
        check("reset_hi",      hi,      0);
        check("reset_lo",      lo,      0);
        check("reset_stall",   stall,   0);
        check("reset_mf_data", mf_data, 0);
        start = 1'b0;
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_busy", busy, 0);

        // ------------------------------------------------------ vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, lat, bcyc);
            check($sformatf("vec%0d_latency", i), lat,  LAT);
            check($sformatf("vec%0d_busy_cycles", i), bcyc, LAT);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].eh);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].el);
`ifdef MULDIV_DIVZ_EN
            check($sformatf("vec%0d_div_zero", i), div_zero, vecs[i].dz);
`endif
            funct = F_MFHI; #1;
            check($sformatf("vec%0d_mfhi", i), mf_data, vecs[i].eh);
            funct = F_MFLO; #1;
            check($sformatf("vec%0d_mflo", i), mf_data, vecs[i].el);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_one_cycle", i), done, 0);
        end

        // ------------------------------- MFHI while MULT in flight (hi=0x64 before)
        run_op(F_DIVU, 32'h64, 32'h0, lat, bcyc);
        funct = F_MULT; op_a = 32'hFFFF_FFFD; op_b = 32'h5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; bad = 0;
        while (done !== 1'b1 && n < LAT_MAX) begin
            if (n == 4) begin
                funct = F_MFHI;
                start = 1'b1;
            end
            if (n >= 4) begin
                #1;
                if (stall !== 1'b1) bad++;
            end
            @(posedge clk); #1;
            n++;
        end
        $display("op MFHI during MULT -> mf_data=%h latency=%0d", mf_data, n);
        check("mf_stall_cycles_missing", bad, 0);
        check("mf_latency", n, LAT);
        check("mf_stall_in_done_cycle", stall, 0);
        check("mf_data_new_hi", mf_data, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("mf_does_not_start_op", busy, 0);
        start = 1'b0;

        // ----------------- back-to-back: MULT accepted in the done cycle of DIV
        run_op(F_DIV, 32'hFFFF_FFF9, 32'h2, lat, bcyc);
        check("b2b_div_latency", lat, LAT);
        old_hi = hi;
        old_lo = lo;
        funct = F_MULT; op_a = 32'h0001_2345; op_b = 32'h0000_0100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accepted_in_done_cycle", busy, 1);
        n = 0; bad = 0; bad_hold = 0;
        while (done !== 1'b1 && n < LAT_MAX) begin
            if (n >= 2 && n <= 4) begin
                // A new start while busy must stall and be ignored.
                funct = F_DIVU; op_a = 32'h64; op_b = 32'h7; start = 1'b1;
                #1;
                if (stall !== 1'b1) bad++;
            end else begin
                start = 1'b0;
            end
            if (hi !== old_hi || lo !== old_lo) bad_hold++;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        $display("op b2b MULT -> hi=%h lo=%h latency=%0d", hi, lo, n);
        check("b2b_stall_while_busy", bad, 0);
        check("b2b_first_result_held", bad_hold, 0);
        check("b2b_latency", n, LAT);
        check("b2b_hi", hi, 32'h0000_0000);
        check("b2b_lo", lo, 32'h0123_4500);

        // --------------------------------------- flush 10 cycles after start
        @(posedge clk); #1;
        old_hi = hi;
        old_lo = lo;
        funct = F_DIVU; op_a = 32'h64; op_b = 32'h7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy_cleared", busy, 0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        $display("op flushed DIVU -> hi=%h lo=%h", hi, lo);
        check("flush_no_done", ndone, 0);
        check("flush_hi_kept", hi, old_hi);
        check("flush_lo_kept", lo, old_lo);

        // ---------------------------------- flush and start in the same cycle
        funct = F_MULT; op_a = 32'h3; op_b = 32'h3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_not_accepted", busy, 0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        $display("op MULT with flush -> hi=%h lo=%h", hi, lo);
        check("flush_start_no_done", ndone, 0);
        check("flush_start_hi_kept", hi, old_hi);

        // ------------------------------------------------------- randomized
        for (int i = 0; i < 40; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            int          sel;
            case ($urandom_range(0, 3))
                0:       f = F_MULT;
                1:       f = F_MULTU;
                2:       f = F_DIV;
                default: f = F_DIVU;
            endcase
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = b & 32'hFF;
            if (sel == 3) a = a | 32'h8000_0000;
            ref_model(f, a, b, eh, el);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_op(f, a, b, lat, bcyc);
            check($sformatf("rand%0d_latency", i), lat, LAT);
            check($sformatf("rand%0d_hi", i), hi, eh);
            check($sformatf("rand%0d_lo", i), lo, el);
        end

        // ------------------------------------------------ reset mid-operation
        @(posedge clk); #1;
        funct = F_MULT; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        $display("op reset mid-MULT -> hi=%h lo=%h busy=%0d", hi, lo, busy);
        check("midreset_busy", busy, 0);
        check("midreset_hi",   hi,   0);
        check("midreset_lo",   lo,   0);
        check("midreset_done", done, 0);
        #2;
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("midreset_op_lost", ndone, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
